four_bit_rca: RTL and testbench
===============================

Name: four_bit_rca

Overview:
- 4-bit ripple-carry adder: adds A, B and carry-in Cin, producing a 4-bit sum and a carry-out.
- Built structurally from a chain of single-bit full-adder cells.
- Sum, carry and status flags are captured in output registers.
- Used as a small arithmetic leaf block and as the adder reference for datapath integration.

Parameters:
- WIDTH, 4, operand/sum width in bits; the block is specified and verified at 4.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- A  input  WIDTH  operand A, unsigned (also interpreted as two's complement for Ovf).
- B  input  WIDTH  operand B, same interpretation as A.
- Cin  input  1  carry into bit 0.
- S  output  WIDTH  registered sum, A+B+Cin mod 2^WIDTH.
- Cout  output  1  registered carry out of the MSB cell.
- Ovf  output  1  registered signed overflow flag.
- Zero  output  1  registered flag, high when the sum is all zeros.

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - rst is asynchronous and active-high: assertion immediately forces S=0, Cout=0, Ovf=0, Zero=0, independent of clk.
  - While rst is high, outputs hold those values.
  - The first capture happens on the first rising clk edge after rst deasserts.
- Datapath is combinational:
  - Cell i computes s[i] = A[i]^B[i]^c[i] and c[i+1] = (A[i]&B[i]) | (c[i]&(A[i]^B[i])).
  - c[0] = Cin.
  - Carry ripples from bit 0 to bit WIDTH-1. No lookahead or carry-select.
- Registered outputs, one cycle latency:
  - On each rising clk edge with rst low: S <= s, Cout <= c[WIDTH], Ovf <= c[WIDTH]^c[WIDTH-1], Zero <= (s==0).
  - Operands present at edge N appear on the outputs after edge N and are stable until edge N+1.
- Capture control:
  - Outputs update every cycle; there is no enable or handshake.
  - Inputs must be stable for the combinational ripple path before the edge; A, B and Cin are not registered internally.
- Arithmetic rules:
  - {Cout,S} equals the full 5-bit unsigned sum A+B+Cin, range 0..31.
  - Wrap-around: S carries only the low 4 bits; for example 15+1 gives S=0, Cout=1, Zero=1.
- Flag independence:
  - Zero reflects S only and ignores Cout.
  - Ovf is computed for every operation regardless of how the operands are interpreted.
- Reset mid-operation:
  - Asserting rst between edges clears the outputs at once.
  - Operands applied during reset are discarded.
  - After release, the next edge captures whatever operands are current then.
- No X propagation from internal state: all output registers are reset.

Test Plan:
- Reset: hold rst=1 with A=4'b0101, B=4'b0011, Cin=0, and toggle clk -> S=0, Cout=0, Ovf=0, Zero=0 throughout. Release rst, clock once -> S=4'b1000, Cout=0, Ovf=1, Zero=0.
- Basic add: A=4'b0001, B=4'b0010, Cin=0 -> one edge later S=4'b0011, Cout=0, Ovf=0, Zero=0. Then A=4'b0101, B=4'b0011 -> S=4'b1000, Cout=0, Ovf=1.
- Wrap and carry:
  - A=4'b1111, B=4'b0001, Cin=0 -> S=4'b0000, Cout=1, Zero=1, Ovf=0.
  - A=4'b1111, B=4'b1111, Cin=1 -> S=4'b1111, Cout=1, Ovf=0.
- Carry-in and zero: A=0, B=0, Cin=1 -> S=4'b0001, Zero=0. A=0, B=0, Cin=0 -> S=0, Zero=1, Cout=0.
- Signed overflow: A=4'b1000, B=4'b1000, Cin=0 -> S=0, Cout=1, Ovf=1, Zero=1. A=4'b0111, B=4'b1001 -> S=0, Cout=1, Ovf=0.
- Exhaustive and latency:
  - Sweep all 512 combinations of A, B, Cin, one per cycle.
  - Check that {Cout,S} equals A+B+Cin from the previous cycle.
  - Assert rst asynchronously mid-sweep -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/four_bit_rca.sv
// Ripple-carry adder built from a chain of full-adder cells.
// Sum, carry-out, signed-overflow and zero flag are registered (one cycle latency).

module rca_full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

module four_bit_rca #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] s_d,    s_q;
  logic             cout_d, cout_q;
  logic             ovf_d,  ovf_q;
  logic             zero_d, zero_q;

  assign c[0] = Cin;

  // Carry ripples strictly bit 0 -> MSB through the cell chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rca_full_adder_cell u_fa (
      .a_i (A[i]),
      .b_i (B[i]),
      .c_i (c[i]),
      .s_o (s[i]),
      .c_o (c[i+1])
    );
  end

  always_comb begin
    s_d    = s;
    cout_d = c[WIDTH];
    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
    zero_d = (s == '0);
  end

  // ---- output register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_four_bit_rca.sv
// Directed and exhaustive checks of four_bit_rca: reset, flags, wrap, latency, async reset.

module tb_four_bit_rca;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       Ovf;
  logic       Zero;

  int n_checks;
  int n_fail;

  four_bit_rca #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout),
    .Ovf  (Ovf),
    .Zero (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Packs outputs as {Ovf, Zero, Cout, S[3:0]}.
  function automatic logic [6:0] outs();
    return {Ovf, Zero, Cout, S};
  endfunction

  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic [3:0] es, input logic ec,
                       input logic eo, input logic ez);
    @(negedge clk);
    A = a; B = b; Cin = cin;
    @(posedge clk);
    #1;
    check({tag, "_S"},    32'(S),    32'(es));
    check({tag, "_Cout"}, 32'(Cout), 32'(ec));
    check({tag, "_Ovf"},  32'(Ovf),  32'(eo));
    check({tag, "_Zero"}, 32'(Zero), 32'(ez));
  endtask

  initial begin
    logic [4:0] sum;
    logic [6:0] exp_o;
    logic [6:0] prev_o;
    logic [3:0] a, b;
    logic       cin;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    A = 4'b0101; B = 4'b0011; Cin = 1'b0;

    // Reset held while clock runs with live operands.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'(outs()), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_S",    32'(S),    32'b1000);
    check("post_reset_Cout", 32'(Cout), 32'd0);
    check("post_reset_Ovf",  32'(Ovf),  32'd1);
    check("post_reset_Zero", 32'(Zero), 32'd0);

    apply("basic1",   4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
    apply("basic2",   4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);
    apply("wrap1",    4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    apply("wrap2",    4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    apply("cin_only", 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    apply("all_zero", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    apply("ovf_neg",  4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    apply("no_ovf",   4'b0111, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);

    // Exhaustive sweep with independent reference model.
    prev_o = outs();
    for (int v = 0; v < 512; v++) begin
      a   = v[3:0];
      b   = v[7:4];
      cin = v[8];
      @(negedge clk);
      A = a; B = b; Cin = cin;
      #1;
      check("hold_until_edge", 32'(outs()), 32'(prev_o));
      if (v == 300) begin
        rst = 1'b1;
        #1;
        check("async_reset", 32'(outs()), 32'd0);
        #1;
        rst = 1'b0;
      end
      sum   = 5'(a) + 5'(b) + 5'(cin);
      exp_o = {(a[3] == b[3]) && (sum[3] != a[3]), sum[3:0] == 4'd0, sum};
      @(posedge clk);
      #1;
      check("sweep", 32'(outs()), 32'(exp_o));
      prev_o = exp_o;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
